// File: rtl/boot_sram_arbiter.sv
// Boot-write FIFO in front of the shared single-port SRAM. Boot words drain into the macro
// first; the core bus gets the SRAM only once boot is done and every queued word is written.
module boot_sram_arbiter #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned ADDR_W         = 10,
  parameter logic [31:0] SRAM_BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              boot_wr_en_i,
  input  logic [31:0]       boot_addr_i,
  input  logic [31:0]       boot_data_i,
  input  logic              boot_done_i,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [31:0]       core_addr_i,
  input  logic [31:0]       core_wdata_i,
  input  logic [3:0]        core_be_i,
  output logic              core_gnt_o,
  output logic              core_rvalid_o,
  output logic [31:0]       core_rdata_o,
  output logic              sram_cs_o,
  output logic              sram_we_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [31:0]       sram_wdata_o,
  output logic [3:0]        sram_be_o,
  input  logic [31:0]       sram_rdata_i,
  input  logic              sram_ready_i,
  output logic              cores_en_o,
  output logic              boot_err_o
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StBoot, StDrain, StRun} state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } entry_t;

  state_e          state_q;
  logic            cores_en_q;
  logic            err_q;

  entry_t          fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;

  logic            rvalid_q;
  logic            rd_oor_q;
  logic [31:0]     rdata_hold_q;

  logic [31:0]     boot_off, core_off;
  logic            boot_in_range, core_in_range;
  logic            boot_phase;
  logic            fifo_empty, fifo_full;
  logic            push_req, push, pop, overflow, err_event;
  logic            core_access;

  // Unsigned wrap on the subtraction makes addresses below the base land out of range.
  assign boot_off      = boot_addr_i - SRAM_BASE_ADDR;
  assign core_off      = core_addr_i - SRAM_BASE_ADDR;
  assign boot_in_range = (boot_off >> (ADDR_W + 2)) == '0;
  assign core_in_range = (core_off >> (ADDR_W + 2)) == '0;

  assign boot_phase = (state_q != StRun);
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));

  assign pop       = !fifo_empty && sram_ready_i && boot_phase;
  assign push_req  = boot_wr_en_i && boot_phase && boot_in_range;
  // A full FIFO still takes a word if the head leaves in the same cycle.
  assign push      = push_req && (!fifo_full || pop);
  assign overflow  = push_req && fifo_full && !pop;
  assign err_event = (boot_wr_en_i && !boot_phase) || (boot_wr_en_i && !boot_in_range) ||
                     overflow;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= '{addr: boot_off[ADDR_W+1:2], data: boot_data_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  // DRAIN looks at the post-pop occupancy so the cores are released the cycle after the
  // last boot word reaches the macro.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= StBoot;
      cores_en_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (err_event) err_q <= 1'b1;
      unique case (state_q)
        StBoot: begin
          if (boot_done_i) state_q <= StDrain;
        end
        StDrain: begin
          if (count_d == '0) begin
            state_q    <= StRun;
            cores_en_q <= 1'b1;
          end
        end
        StRun: begin
          state_q <= StRun;
        end
        default: begin
          state_q    <= StBoot;
          cores_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign cores_en_o = cores_en_q;
  assign boot_err_o = err_q;

  assign core_gnt_o  = core_req_i && (state_q == StRun) && sram_ready_i;
  assign core_access = core_gnt_o && core_in_range;

  always_comb begin
    sram_cs_o    = 1'b0;
    sram_we_o    = 1'b0;
    sram_be_o    = 4'h0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    if (pop) begin
      sram_cs_o    = 1'b1;
      sram_we_o    = 1'b1;
      sram_be_o    = 4'hF;
      sram_addr_o  = fifo_q[rd_ptr_q].addr;
      sram_wdata_o = fifo_q[rd_ptr_q].data;
    end else if (core_access) begin
      sram_cs_o    = 1'b1;
      sram_we_o    = core_we_i;
      sram_be_o    = core_be_i;
      sram_addr_o  = core_off[ADDR_W+1:2];
      sram_wdata_o = core_wdata_i;
    end
  end

  // Out-of-range reads never touch the macro and return zero.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rvalid_q     <= 1'b0;
      rd_oor_q     <= 1'b0;
      rdata_hold_q <= '0;
    end else begin
      rvalid_q <= core_gnt_o && !core_we_i;
      rd_oor_q <= !core_in_range;
      if (rvalid_q) rdata_hold_q <= core_rdata_o;
    end
  end

  assign core_rvalid_o = rvalid_q;
  assign core_rdata_o  = rvalid_q ? (rd_oor_q ? 32'h0 : sram_rdata_i) : rdata_hold_q;

endmodule

// File: tb/tb_boot_sram_arbiter.sv
// Self-checking bench for boot_sram_arbiter: behavioural SRAM, scoreboard of expected macro
// writes and read returns, table-driven boot and core vectors plus boot corner sequences.
module tb_boot_sram_arbiter;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        boot_wr_en_i, boot_done_i;
  logic [31:0] boot_addr_i, boot_data_i;
  logic        core_req_i, core_we_i;
  logic [31:0] core_addr_i, core_wdata_i;
  logic [3:0]  core_be_i;
  logic        core_gnt_o, core_rvalid_o;
  logic [31:0] core_rdata_o;
  logic        sram_cs_o, sram_we_o;
  logic [9:0]  sram_addr_o;
  logic [31:0] sram_wdata_o;
  logic [3:0]  sram_be_o;
  logic [31:0] sram_rdata_i = 32'h0;
  logic        sram_ready_i;
  logic        cores_en_o, boot_err_o;

  always #5 clk = ~clk;

  boot_sram_arbiter #(
    .FIFO_DEPTH    (4),
    .ADDR_W        (10),
    .SRAM_BASE_ADDR(32'h0000_0000)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .boot_wr_en_i (boot_wr_en_i),
    .boot_addr_i  (boot_addr_i),
    .boot_data_i  (boot_data_i),
    .boot_done_i  (boot_done_i),
    .core_req_i   (core_req_i),
    .core_we_i    (core_we_i),
    .core_addr_i  (core_addr_i),
    .core_wdata_i (core_wdata_i),
    .core_be_i    (core_be_i),
    .core_gnt_o   (core_gnt_o),
    .core_rvalid_o(core_rvalid_o),
    .core_rdata_o (core_rdata_o),
    .sram_cs_o    (sram_cs_o),
    .sram_we_o    (sram_we_o),
    .sram_addr_o  (sram_addr_o),
    .sram_wdata_o (sram_wdata_o),
    .sram_be_o    (sram_be_o),
    .sram_rdata_i (sram_rdata_i),
    .sram_ready_i (sram_ready_i),
    .cores_en_o   (cores_en_o),
    .boot_err_o   (boot_err_o)
  );

  // Behavioural single-port SRAM: byte-masked writes, read data one cycle later.
  logic [31:0] mem [1024] = '{default: 32'h0};
  always @(posedge clk) begin
    if (sram_cs_o && sram_ready_i) begin
      if (sram_we_o) begin
        for (int b = 0; b < 4; b++) begin
          if (sram_be_o[b]) mem[sram_addr_o][8*b +: 8] <= sram_wdata_o[8*b +: 8];
        end
      end else begin
        sram_rdata_i <= mem[sram_addr_o];
      end
    end
  end

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [9:0]  exp_word;
  } boot_vec_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        exp_cs;
    logic [9:0]  exp_word;
    logic [31:0] exp_rdata;
  } core_vec_t;

  wr_t         exp_wr[$];
  logic [31:0] exp_rd[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One clock; the SRAM pins and read returns are scored at the falling edge.
  task automatic tick();
    wr_t         e;
    logic [31:0] r;
    @(negedge clk);
    if (!sram_ready_i) chk("cs_while_not_ready", sram_cs_o, 0);
    if (!sram_cs_o) chk("idle_we_be", {sram_we_o, sram_be_o}, 0);
    if (sram_cs_o && sram_we_o && sram_ready_i) begin
      if (exp_wr.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_sram_write: got addr %h data %h, expected no write",
                 sram_addr_o, sram_wdata_o);
      end else begin
        e = exp_wr.pop_front();
        chk("sram_wr_addr", sram_addr_o, e.addr);
        chk("sram_wr_data", sram_wdata_o, e.data);
        chk("sram_wr_be", sram_be_o, e.be);
      end
    end
    if (core_rvalid_o) begin
      if (exp_rd.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rvalid: got rdata %h, expected no rvalid", core_rdata_o);
      end else begin
        r = exp_rd.pop_front();
        chk("core_rdata", core_rdata_o, r);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_i      = 1'b1;
    boot_wr_en_i = 1'b0;
    boot_addr_i  = '0;
    boot_data_i  = '0;
    boot_done_i  = 1'b0;
    core_req_i   = 1'b0;
    core_we_i    = 1'b0;
    core_addr_i  = '0;
    core_wdata_i = '0;
    core_be_i    = '0;
    sram_ready_i = 1'b0;
    cyc();
    cyc();
    reset_i = 1'b0;
  endtask

  task automatic boot_write(input logic [31:0] a, input logic [31:0] d, input bit expect_push,
                            input logic [9:0] word);
    boot_wr_en_i = 1'b1;
    boot_addr_i  = a;
    boot_data_i  = d;
    if (expect_push) exp_wr.push_back('{word, d, 4'hF});
    tick();
    boot_wr_en_i = 1'b0;
  endtask

  task automatic wait_cores_en(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (cores_en_o) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    chk(name, seen, 1);
  endtask

  boot_vec_t bv[8];
  core_vec_t cv[8];

  initial begin
    for (int i = 0; i < 8; i++) bv[i] = '{32'(4 * i), 32'hB000_0000 + 32'(i), 10'(i)};
    cv[0] = '{1'b1, 32'h40,   32'hDEAD_BEEF, 4'hF, 1'b1, 10'h010, 32'h0};
    cv[1] = '{1'b0, 32'h40,   32'h0,         4'hF, 1'b1, 10'h010, 32'hDEAD_BEEF};
    cv[2] = '{1'b0, 32'h1000, 32'h0,         4'hF, 1'b0, 10'h000, 32'h0};
    cv[3] = '{1'b1, 32'h44,   32'h1234_5678, 4'h3, 1'b1, 10'h011, 32'h0};
    cv[4] = '{1'b0, 32'h44,   32'h0,         4'hF, 1'b1, 10'h011, 32'h0000_5678};
    cv[5] = '{1'b0, 32'hFFC,  32'h0,         4'hF, 1'b1, 10'h3FF, 32'h0};
    cv[6] = '{1'b1, 32'h1000, 32'hAAAA_5555, 4'hF, 1'b0, 10'h000, 32'h0};
    cv[7] = '{1'b0, 32'h0,    32'h0,         4'hF, 1'b1, 10'h000, 32'hB000_0000};

    // Reset state and the in-order boot stream, boot_done on the last word.
    do_reset();
    chk("rst_cs", sram_cs_o, 0);
    chk("rst_gnt", core_gnt_o, 0);
    chk("rst_rvalid", core_rvalid_o, 0);
    chk("rst_rdata", core_rdata_o, 0);
    chk("rst_cores_en", cores_en_o, 0);
    chk("rst_err", boot_err_o, 0);
    sram_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) boot_done_i = 1'b1;
      boot_write(bv[i].addr, bv[i].data, 1'b1, bv[i].exp_word);
      chk("boot_cores_en_low", cores_en_o, 0);
    end
    tick();
    chk("cores_en_after_last", cores_en_o, 1);
    chk("boot_all_written", exp_wr.size(), 0);
    chk("boot_err_clean", boot_err_o, 0);

    // RUN: the core waits while the macro stalls, then the vector table.
    sram_ready_i = 1'b0;
    core_req_i   = 1'b1;
    core_addr_i  = 32'h40;
    #1;
    chk("gnt_not_ready", core_gnt_o, 0);
    tick();
    sram_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      core_we_i    = cv[i].we;
      core_addr_i  = cv[i].addr;
      core_wdata_i = cv[i].wdata;
      core_be_i    = cv[i].be;
      #1;
      chk("core_gnt", core_gnt_o, 1);
      chk("core_cs", sram_cs_o, cv[i].exp_cs);
      if (cv[i].exp_cs) chk("core_addr", sram_addr_o, cv[i].exp_word);
      if (cv[i].we && cv[i].exp_cs) exp_wr.push_back('{cv[i].exp_word, cv[i].wdata, cv[i].be});
      if (!cv[i].we) exp_rd.push_back(cv[i].exp_rdata);
      tick();
    end
    core_req_i = 1'b0;
    tick();
    tick();
    chk("rdata_hold", core_rdata_o, 32'hB000_0000);
    chk("rvalid_pulse", core_rvalid_o, 0);
    boot_write(32'h20, 32'h1111_1111, 1'b0, 10'h0);
    chk("err_boot_in_run", boot_err_o, 1);

    // Stalled macro with exactly FIFO_DEPTH words, including the top word.
    do_reset();
    boot_write(32'h100, 32'hA000_0000, 1'b1, 10'h040);
    boot_write(32'h104, 32'hA000_0001, 1'b1, 10'h041);
    boot_write(32'h108, 32'hA000_0002, 1'b1, 10'h042);
    boot_write(32'hFFC, 32'hA000_0003, 1'b1, 10'h3FF);
    chk("full_no_err", boot_err_o, 0);
    sram_ready_i = 1'b1;
    boot_done_i  = 1'b1;
    wait_cores_en("stall4_released");
    chk("stall4_written", exp_wr.size(), 0);
    chk("stall4_err", boot_err_o, 0);

    // Overflow: fifth word while stalled is dropped.
    do_reset();
    for (int i = 0; i < 4; i++) boot_write(32'h200 + 32'(4 * i), 32'h5000_0000 + 32'(i), 1'b1,
                                           10'h080 + 10'(i));
    chk("ovf_err_before", boot_err_o, 0);
    boot_write(32'h210, 32'h5000_0004, 1'b0, 10'h0);
    chk("ovf_err_set", boot_err_o, 1);
    sram_ready_i = 1'b1;
    boot_done_i  = 1'b1;
    wait_cores_en("ovf_released");
    chk("ovf_first4_written", exp_wr.size(), 0);
    chk("ovf_err_sticky", boot_err_o, 1);

    // boot_done with 3 queued words and a toggling ready: cores held off until drained.
    do_reset();
    boot_write(32'h300, 32'hC000_0000, 1'b1, 10'h0C0);
    boot_write(32'h304, 32'hC000_0001, 1'b1, 10'h0C1);
    boot_write(32'h308, 32'hC000_0002, 1'b1, 10'h0C2);
    boot_done_i = 1'b1;
    core_req_i  = 1'b1;
    core_we_i   = 1'b0;
    core_addr_i = 32'h300;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
        sram_ready_i = i[0];
        #1;
        if (cores_en_o) begin
          seen = 1'b1;
          break;
        end
        chk("drain_no_gnt", core_gnt_o, 0);
        tick();
      end
      chk("drain_released", seen, 1);
    end
    chk("drain_all_written", exp_wr.size(), 0);
    sram_ready_i = 1'b1;
    #1;
    chk("drain_held_req_gnt", core_gnt_o, 1);
    exp_rd.push_back(32'hC000_0000);
    tick();
    core_req_i = 1'b0;
    tick();

    // Mid-boot reset discards queued words; then an out-of-range boot write.
    do_reset();
    boot_write(32'h400, 32'hE000_0000, 1'b0, 10'h0);
    boot_write(32'h404, 32'hE000_0001, 1'b0, 10'h0);
    reset_i = 1'b1;
    cyc();
    reset_i      = 1'b0;
    sram_ready_i = 1'b1;
    core_req_i   = 1'b1;
    #1;
    chk("mid_rst_cs", sram_cs_o, 0);
    chk("mid_rst_gnt", core_gnt_o, 0);
    chk("mid_rst_cores_en", cores_en_o, 0);
    chk("mid_rst_err", boot_err_o, 0);
    chk("mid_rst_rvalid", core_rvalid_o, 0);
    tick();
    core_req_i = 1'b0;
    boot_write(32'h1000, 32'hF000_0000, 1'b0, 10'h0);
    chk("oor_boot_err", boot_err_o, 1);
    tick();

    chk("sb_wr_empty", exp_wr.size(), 0);
    chk("sb_rd_empty", exp_rd.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
